// File: rtl/counter_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
//   Shared definitions for the triangle-sweep controller:
//     - sweep_state_t   : controller state encoding (also exported for debug)
//     - N_DEFAULT       : default width of reference value / counter feedback
//     - TICK_DIV_DEFAULT: default number of clock cycles between counter commands
//     - is_sweeping()   : true in the states where the tick divider runs
// -----------------------------------------------------------------------------
package sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DOWN  = 3'd2,
        ST_UP    = 3'd3,
        ST_FAULT = 3'd4
    } sweep_state_t;

    localparam int N_DEFAULT        = 32;
    localparam int TICK_DIV_DEFAULT = 4;

    // Only the two ramp states issue counter commands, so only they let the
    // tick divider count; every other state holds it cleared.
    function automatic logic is_sweeping(input sweep_state_t s);
        return (s == ST_DOWN) || (s == ST_UP);
    endfunction

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl_if
//   Bundles every non-clock/reset signal of the sweep controller.
//
//   Control side (driven by the master):
//     start          level, sampled only while the controller is idle
//     stop           level, aborts any activity, wins over everything else
//     ref_value      sweep top value, captured when a start is accepted
//   Counter side:
//     counter_value  feedback from the driven up/down counter (master drives)
//     threshold_in   counter above-reference flag (master drives)
//     enable         count-enable command (slave drives)
//     dec            direction, 1 = decrement, 0 = increment (slave drives)
//     load           load command, counter takes load_ref_value (slave drives)
//     load_ref_value captured reference value (slave drives)
//   Status (slave drives): busy, fault, sweep_count, dbg_state
//
//   Command semantics: there is no back-pressure. A command is a single-cycle
//   pulse; the counter must act on enable/load in the cycle they are high.
//   enable and load are never high together, and dec is only meaningful in a
//   cycle where enable is high.
// -----------------------------------------------------------------------------
interface counter_sweep_ctrl_if #(
    parameter int N = 32
);
    import sweep_pkg::*;

    logic               start;
    logic               stop;
    logic [N-1:0]       ref_value;
    logic [N-1:0]       counter_value;
    logic               threshold_in;
    logic               enable;
    logic               dec;
    logic               load;
    logic [N-1:0]       load_ref_value;
    logic               busy;
    logic               fault;
    logic [7:0]         sweep_count;
    sweep_state_t       dbg_state;

    modport master (
        output start,
        output stop,
        output ref_value,
        output counter_value,
        output threshold_in,
        input  enable,
        input  dec,
        input  load,
        input  load_ref_value,
        input  busy,
        input  fault,
        input  sweep_count,
        input  dbg_state
    );

    modport slave (
        input  start,
        input  stop,
        input  ref_value,
        input  counter_value,
        input  threshold_in,
        output enable,
        output dec,
        output load,
        output load_ref_value,
        output busy,
        output fault,
        output sweep_count,
        output dbg_state
    );

endinterface

// File: rtl/counter_sweep_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Free-running divider producing a one-cycle tick every TICK_DIV cycles.
//   While i_clear is high the count is held at zero and no tick is produced,
//   so the first tick after i_clear drops arrives TICK_DIV cycles later.
//
//   Ports:
//     i_clock    system clock, rising edge
//     i_reset_n  asynchronous active-low reset
//     i_clear    synchronous clear / hold
//     o_tick     one-cycle pulse
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    // TICK_DIV is at least 2, so the width is at least one bit; 2^16 needs 16.
    localparam int         W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_count;
    logic         w_last;

    assign w_last = (r_count == LAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = w_last && !i_clear;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl
//   Drives an external up/down counter with load through a triangle sweep
//   ref -> 0 -> ref -> 0 ... . On an accepted start the reference is captured
//   and a load command is issued; then, every TICK_DIV cycles, one
//   decrement/increment command is issued, turning around at 0 and at the
//   captured reference. Each turnaround at 0 counts one completed period.
//   An above-reference flag from the counter latches a sticky fault.
//
//   Ports:
//     i_clock    system clock, rising edge
//     i_reset_n  asynchronous active-low reset
//     bus        counter_sweep_ctrl_if.slave: start/stop/ref_value in,
//                counter_value/threshold_in feedback in, enable/dec/load/
//                load_ref_value commands out, busy/fault/sweep_count/
//                dbg_state status out
//
//   All outputs are registers; a decision taken at the edge ending a tick
//   cycle appears on the outputs in the following cycle.
// -----------------------------------------------------------------------------
module counter_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    counter_sweep_ctrl_if.slave bus
);

    sweep_state_t   r_state;
    logic [N-1:0]   r_ref_q;
    logic           r_enable;
    logic           r_dec;
    logic           r_load;
    logic           r_busy;
    logic           r_fault;
    logic [7:0]     r_sweep_count;

    logic           w_tick;
    logic           w_tick_clear;
    logic           w_at_floor;
    logic           w_at_top;

    // The divider restarts whenever we are outside the ramp states, so the
    // first tick lands TICK_DIV cycles after leaving LOAD.
    assign w_tick_clear = !is_sweeping(r_state);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_tick_clear),
        .o_tick    (w_tick)
    );

    assign w_at_floor = (bus.counter_value == '0);
    assign w_at_top   = (bus.counter_value == r_ref_q);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_ref_q       <= '0;
            r_enable      <= 1'b0;
            r_dec         <= 1'b0;
            r_load        <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_sweep_count <= 8'd0;
        end else begin
            // Commands are single-cycle pulses unless re-asserted below.
            r_enable <= 1'b0;
            r_load   <= 1'b0;

            if (bus.stop) begin
                // stop outranks start, threshold_in and any pending tick.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_ref_q       <= bus.ref_value;
                            r_sweep_count <= 8'd0;
                            r_fault       <= 1'b0;
                            r_load        <= 1'b1;
                            r_busy        <= 1'b1;
                            r_state       <= ST_LOAD;
                        end
                    end

                    ST_LOAD: begin
                        // A zero reference has nothing to sweep: the load
                        // alone is the whole operation.
                        if (r_ref_q == '0) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DOWN;
                        end
                    end

                    ST_DOWN: begin
                        if (bus.threshold_in) begin
                            r_fault <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FAULT;
                        end else if (w_tick) begin
                            r_enable <= 1'b1;
                            if (w_at_floor) begin
                                r_dec         <= 1'b0;
                                r_sweep_count <= r_sweep_count + 8'd1;
                                r_state       <= ST_UP;
                            end else begin
                                r_dec <= 1'b1;
                            end
                        end
                    end

                    ST_UP: begin
                        if (bus.threshold_in) begin
                            r_fault <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FAULT;
                        end else if (w_tick) begin
                            r_enable <= 1'b1;
                            if (w_at_top) begin
                                r_dec   <= 1'b1;
                                r_state <= ST_DOWN;
                            end else begin
                                r_dec <= 1'b0;
                            end
                        end
                    end

                    ST_FAULT: begin
                        // Parked until stop; fault stays set until the next
                        // accepted start.
                    end

                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.enable         = r_enable;
    assign bus.dec            = r_dec;
    assign bus.load           = r_load;
    assign bus.load_ref_value = r_ref_q;
    assign bus.busy           = r_busy;
    assign bus.fault          = r_fault;
    assign bus.sweep_count    = r_sweep_count;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_sweep_ctrl
//   Directed bench for counter_sweep_ctrl with N=8, TICK_DIV=2, an
//   up/down counter with load closing the loop, a cycle-level reference
//   model of the controller, and hand-computed literal checkpoints.
// -----------------------------------------------------------------------------
module tb_counter_sweep_ctrl;
    import sweep_pkg::*;

    localparam int N        = 8;
    localparam int TICK_DIV = 2;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_DOWN  = 2;
    localparam int M_UP    = 3;
    localparam int M_FAULT = 4;

    // ---------------------------------------------------------------- clock/reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_on      = 1'b0;

    counter_sweep_ctrl_if #(.N(N)) bus ();

    counter_sweep_ctrl #(
        .N        (N),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    // ---------------------------------------------------------------- counter plant
    logic [N-1:0] plant_cnt = '0;
    logic [N-1:0] p_nxt;
    logic [N-1:0] hist_q[$];
    logic         thr_force = 1'b0;

    assign bus.counter_value = plant_cnt;
    assign bus.threshold_in  = thr_force;

    always @(posedge clk) begin
        if (bus.load) begin
            plant_cnt <= bus.load_ref_value;
            hist_q.push_back(bus.load_ref_value);
        end else if (bus.enable) begin
            p_nxt = bus.dec ? (plant_cnt - 1'b1) : (plant_cnt + 1'b1);
            plant_cnt <= p_nxt;
            hist_q.push_back(p_nxt);
        end
    end

    // ---------------------------------------------------------------- reference model
    // Mode, age (cycles spent ramping since LOAD) and period count as plain
    // integers; a command is due whenever age is a multiple of TICK_DIV.
    int           m_mode   = M_IDLE;
    int           m_age    = 0;
    int           m_sweeps = 0;
    logic [N-1:0] m_ref    = '0;
    logic         e_enable = 1'b0;
    logic         e_dec    = 1'b0;
    logic         e_load   = 1'b0;
    logic         e_busy   = 1'b0;
    logic         e_fault  = 1'b0;
    logic         m_tick;
    bit           at_bound;
    bit           going_down;

    assign m_tick = ((m_mode == M_DOWN) || (m_mode == M_UP)) && ((m_age % TICK_DIV) == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode   <= M_IDLE;
            m_age    <= 0;
            m_sweeps <= 0;
            m_ref    <= '0;
            e_enable <= 1'b0;
            e_dec    <= 1'b0;
            e_load   <= 1'b0;
            e_busy   <= 1'b0;
            e_fault  <= 1'b0;
        end else begin
            e_enable <= 1'b0;
            e_load   <= 1'b0;
            if (bus.stop) begin
                m_mode <= M_IDLE;
                e_busy <= 1'b0;
            end else if (m_mode == M_IDLE) begin
                if (bus.start) begin
                    m_ref    <= bus.ref_value;
                    m_sweeps <= 0;
                    e_fault  <= 1'b0;
                    e_load   <= 1'b1;
                    e_busy   <= 1'b1;
                    m_mode   <= M_LOAD;
                end
            end else if (m_mode == M_LOAD) begin
                if (m_ref == 0) begin
                    m_mode <= M_IDLE;
                    e_busy <= 1'b0;
                end else begin
                    m_mode <= M_DOWN;
                    m_age  <= 1;
                end
            end else if ((m_mode == M_DOWN) || (m_mode == M_UP)) begin
                if (bus.threshold_in) begin
                    m_mode  <= M_FAULT;
                    e_fault <= 1'b1;
                    e_busy  <= 1'b0;
                end else begin
                    m_age <= m_age + 1;
                    if (m_tick) begin
                        at_bound   = (m_mode == M_DOWN) ? (plant_cnt == 0) : (plant_cnt == m_ref);
                        going_down = (m_mode == M_DOWN) != at_bound;
                        e_enable <= 1'b1;
                        e_dec    <= going_down;
                        m_mode   <= going_down ? M_DOWN : M_UP;
                        if ((m_mode == M_DOWN) && at_bound) m_sweeps <= m_sweeps + 1;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_enable",      {31'd0, bus.enable},  {31'd0, e_enable});
            check("model_dec",         {31'd0, bus.dec},     {31'd0, e_dec});
            check("model_load",        {31'd0, bus.load},    {31'd0, e_load});
            check("model_busy",        {31'd0, bus.busy},    {31'd0, e_busy});
            check("model_fault",       {31'd0, bus.fault},   {31'd0, e_fault});
            check("model_sweep_count", {24'd0, bus.sweep_count}, {24'd0, m_sweeps[7:0]});
            check("model_ref_q",       {24'd0, bus.load_ref_value}, {24'd0, m_ref});
            check("cmd_exclusive",     {31'd0, bus.enable & bus.load}, 32'd0);
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic wait_mode(input int mode, input int budget, input string name);
        for (int i = 0; i < budget && m_mode != mode; i++) @(negedge clk);
        if (m_mode != mode) timeout(name);
    endtask

    task automatic wait_hist(input int n, input int budget);
        for (int i = 0; i < budget && hist_q.size() < n; i++) @(negedge clk);
        if (hist_q.size() < n) timeout("wait_hist");
    endtask

    // Drives start for one cycle; returns at the negedge of the LOAD cycle.
    task automatic pulse_start(input logic [N-1:0] r);
        bus.ref_value = r;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"}, {31'd0, bus.enable}, 32'd0);
        check({tag, "_dec"},    {31'd0, bus.dec},    32'd0);
        check({tag, "_load"},   {31'd0, bus.load},   32'd0);
        check({tag, "_busy"},   {31'd0, bus.busy},   32'd0);
        check({tag, "_fault"},  {31'd0, bus.fault},  32'd0);
        check({tag, "_sweep"},  {24'd0, bus.sweep_count},    32'd0);
        check({tag, "_refq"},   {24'd0, bus.load_ref_value}, 32'd0);
    endtask

    // ---------------------------------------------------------------- stimulus
    logic [N-1:0] exp_q[$];

    initial begin
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.ref_value = '0;

        // Reset state.
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        check("reset_state", {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        @(negedge clk);

        // Closed-loop sweep, ref 3: load next cycle, then 3,2,1,0,1,2,3,2.
        hist_q.delete();
        pulse_start(8'd3);
        check("start_load",  {31'd0, bus.load}, 32'd1);
        check("start_busy",  {31'd0, bus.busy}, 32'd1);
        check("start_refq",  {24'd0, bus.load_ref_value}, 32'd3);
        bus.ref_value = 8'hAA;
        wait_hist(8, 100);
        exp_q = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3, 8'd2};
        for (int i = 0; i < 8; i++) begin
            check("sweep_seq", {24'd0, (hist_q.size() > 0) ? hist_q.pop_front() : 8'hFF},
                  {24'd0, exp_q.pop_front()});
        end
        check("sweep_count_one", {24'd0, bus.sweep_count}, 32'd1);
        check("refq_held",       {24'd0, bus.load_ref_value}, 32'd3);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("stop_busy", {31'd0, bus.busy}, 32'd0);

        // Zero reference: a single load, then idle, never an enable.
        @(negedge clk);
        pulse_start(8'd0);
        check("ref0_load", {31'd0, bus.load}, 32'd1);
        @(negedge clk);
        check("ref0_load_gone", {31'd0, bus.load}, 32'd0);
        check("ref0_busy",      {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("ref0_no_enable", {31'd0, bus.enable}, 32'd0);
            @(negedge clk);
        end

        // Threshold while ramping up -> sticky fault until a new start.
        pulse_start(8'd3);
        wait_mode(M_UP, 100, "wait_up");
        thr_force = 1'b1;
        @(negedge clk);
        check("fault_set",     {31'd0, bus.fault},  32'd1);
        check("fault_no_en",   {31'd0, bus.enable}, 32'd0);
        check("fault_busy",    {31'd0, bus.busy},   32'd0);
        check("fault_state",   {29'd0, bus.dbg_state}, {29'd0, ST_FAULT});
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("fault_hold",    {31'd0, bus.fault},  32'd1);
        bus.stop  = 1'b1;
        thr_force = 1'b0;
        @(negedge clk);
        bus.stop  = 1'b0;
        check("fault_after_stop", {31'd0, bus.fault}, 32'd1);
        check("idle_after_stop",  {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
        pulse_start(8'd3);
        check("fault_cleared", {31'd0, bus.fault}, 32'd0);

        // stop on a tick cycle suppresses the command; start+stop stays idle.
        for (int i = 0; i < 50 && !m_tick; i++) @(negedge clk);
        if (!m_tick) timeout("wait_tick");
        bus.stop = 1'b1;
        @(negedge clk);
        check("stop_tick_no_en", {31'd0, bus.enable}, 32'd0);
        check("stop_tick_busy",  {31'd0, bus.busy},   32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        check("start_stop_busy", {31'd0, bus.busy}, 32'd0);
        check("start_stop_load", {31'd0, bus.load}, 32'd0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        @(negedge clk);

        // Asynchronous reset between edges mid-ramp.
        pulse_start(8'd5);
        wait_mode(M_DOWN, 20, "wait_down");
        repeat (2) @(negedge clk);
        check("pre_reset_enable", {31'd0, bus.enable}, 32'd1);
        check("pre_reset_dec",    {31'd0, bus.dec},    32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_no_en",   {31'd0, bus.enable}, 32'd0);
            check("post_reset_no_load", {31'd0, bus.load},   32'd0);
        end

        // 256 periods at ref 1: sweep_count wraps, ref_value change ignored.
        pulse_start(8'd1);
        check("wrap_load", {31'd0, bus.load}, 32'd1);
        for (int c = 1; c <= 1021; c++) begin
            @(negedge clk);
            if (c == 500) bus.ref_value = 8'd3;
        end
        check("wrap_255",  {24'd0, bus.sweep_count}, 32'd255);
        check("wrap_cnt_bounded", {31'd0, plant_cnt <= 8'd1}, 32'd1);
        repeat (4) @(negedge clk);
        check("wrap_0",    {24'd0, bus.sweep_count}, 32'd0);
        check("wrap_busy", {31'd0, bus.busy}, 32'd1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        @(negedge clk);

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 Parameter: N, 32, width of the reference value and of the counter feedback.
REQ-002 Parameter: TICK_DIV, 4, clock cycles between counter commands; legal range 2..2^16.
REQ-003 Port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  level; sampled in IDLE to begin a sweep.
REQ-006 Port: stop  input  1  level; aborts any activity.
REQ-007 Port: ref_value  input  N  sweep top value; captured into ref_q on accepted start.
REQ-008 Port: counter_value  input  N  feedback from the driven up/down counter.
REQ-009 Port: threshold_in  input  1  counter above-reference flag from the driven counter.
REQ-010 Port: enable  output  1  counter count-enable command.
REQ-011 Port: dec  output  1  count direction; 1 = decrement, 0 = increment.
REQ-012 Port: load  output  1  counter load command.
REQ-013 Port: load_ref_value  output  N  equals ref_q at all times.
REQ-014 Port: busy  output  1  high in LOAD, DOWN and UP.
REQ-015 Port: fault  output  1  sticky; set on threshold violation.
REQ-016 Port: sweep_count  output  8  completed triangle periods; wraps 255 -> 0.

Function
REQ-017 FSM states: IDLE, LOAD, DOWN, UP, FAULT; all outputs registered.
REQ-018 IDLE: start=1 and stop=0 -> capture ref_q, clear sweep_count, go to LOAD; load=1 in the following cycle only.
REQ-019 LOAD: one cycle; go to DONE-equivalent IDLE if ref_q==0 (no further commands); otherwise go to DOWN and restart the tick divider.
REQ-020 Tick: pulses every TICK_DIV cycles while in DOWN or UP; the first tick occurs TICK_DIV cycles after leaving LOAD.
REQ-021 Commands: enable=1 for exactly the tick cycle; enable, load never high simultaneously; dec valid whenever enable=1.
REQ-022 DOWN at tick: counter_value==0 -> issue increment, go to UP, sweep_count+1; else issue decrement.
REQ-023 UP at tick: counter_value==ref_q -> issue decrement, go to DOWN; else issue increment.
REQ-024 Decisions use counter_value sampled at the tick cycle; TICK_DIV>=2 guarantees feedback settled.
REQ-025 threshold_in=1 in DOWN or UP -> go to FAULT next cycle, set fault, issue no command.
REQ-026 FAULT: hold until stop=1, then IDLE; fault stays set until the next accepted start.
REQ-027 stop=1 in any state -> IDLE next cycle, enable=load=0 that cycle; stop beats start and threshold_in.
REQ-028 start while busy is ignored; ref_value changes after capture have no effect.

Reset
REQ-029 reset=0 forces immediately: state IDLE, enable=dec=load=0, ref_q=0, busy=0, fault=0, sweep_count=0, tick divider=0.
REQ-030 Reset asserted mid-sweep aborts with no further command; operation resumes only on a new start.

Structure
REQ-031 Shared package sweep_pkg holds the state enum typedef and the TICK_DIV default constant.
REQ-032 Tick divider is a sub-module tick_gen (parameter TICK_DIV, inputs clock, reset, clear; output tick).

Verification
REQ-033 Paired with the team's up/down counter with load, configured as N=8, TICK_DIV=2, ref_value=3, start pulse -> load at cycle+1; the counter follows 3,2,1,0,1,2,3,2,...; sweep_count=1 after the first 0->1 step.
REQ-034 ref_value=0, start -> one load pulse, then IDLE, busy=0, enable never asserted.
REQ-035 Force threshold_in=1 while in UP -> FAULT next cycle, fault=1, no enable; stop -> IDLE with fault still 1; new start clears fault.
REQ-036 stop asserted on a tick cycle -> no enable that cycle; IDLE next cycle; start and stop high together in IDLE -> remains IDLE.
REQ-037 reset=0 pulse mid-DOWN (async, between edges) -> all outputs 0 immediately; no commands until the next start.
REQ-038 Run 256 periods at ref_value=1 -> sweep_count wraps to 0; ref_value changed mid-run does not alter turnaround.
